btle_phy_trx_seq: RTL
=====================

// Module: btle_phy_trx_seq
// PURPOSE
//  Half-duplex transmit/receive sequencer that sits beside btle_tx and btle_rx inside the PHY top.
//  It runs TX-only, RX-only, TX-then-RX and RX-then-TX exchanges.
//  Turnaround follows the BLE inter-frame space (T_IFS). It applies an RX listen timeout and a decode watchdog.
//  It reports one completion status per exchange.
// PARAMETERS
//  CLK_FREQ_MHZ       16     clk frequency in MHz (integer)
//  IFS_US             150    inter-frame space in us; localparam IFS_CYCLES = CLK_FREQ_MHZ*IFS_US, must be >= 2
//  TIMER_BIT_WIDTH    24     width of the shared down-counter and of rx_timeout_cycles
//  MAX_DECODE_CYCLES  35200  watchdog from rx_hit_flag to rx_decode_end; 0 disables it
// PORTS
//  clk                in   1   single clock
//  rst                in   1   synchronous, active-high reset
//  start              in   1   one-cycle request; sampled only in IDLE
//  abort              in   1   level; terminates any active exchange
//  mode               in   2   0 TX_ONLY, 1 RX_ONLY, 2 TX_THEN_RX, 3 RX_THEN_TX; latched on an accepted start
//  rx_timeout_cycles  in   TIMER_BIT_WIDTH  listen window in cycles; 0 = unlimited; latched on start
//  tx_end             in   1   last-sample strobe from btle_tx (iq_valid_last or gauss_filter_valid_last)
//  rx_hit_flag        in   1   access-address hit pulse from btle_rx
//  rx_decode_end      in   1   decode-complete pulse from btle_rx
//  rx_crc_ok          in   1   CRC result; valid when rx_decode_end = 1
//  tx_start           out  1   one-cycle pulse to btle_tx
//  rx_enable          out  1   gates rx_iq_valid into btle_rx
//  busy               out  1   high in every state except IDLE
//  done               out  1   one-cycle pulse; coincides with the DONE state
//  status             out  3   0 NONE, 1 OK, 2 RX_TIMEOUT, 3 CRC_ERR, 4 DECODE_TIMEOUT, 5 ABORT; held until the next accepted start
//  state_dbg          out  3   current FSM state encoding
// BEHAVIOUR
//  Reset: state = IDLE. All outputs are 0 and the counter is cleared; this takes effect mid-exchange too.
//  States: IDLE, TX_RUN, IFS_WAIT, RX_LISTEN, RX_DECODE, DONE.
//  IDLE + start (and no abort):
//   - Latch mode and rx_timeout_cycles, clear status to NONE.
//   - Modes 0/2: go to TX_RUN; tx_start pulses in the first TX_RUN cycle (1 cycle after start).
//   - Modes 1/3: go to RX_LISTEN; rx_enable is high from the next cycle; counter = rx_timeout_cycles.
//  TX_RUN on tx_end:
//   - Mode 2: go to IFS_WAIT toward RX.
//   - Modes 0/3: go to DONE, status OK.
//  IFS_WAIT: counter runs so the next phase starts exactly IFS_CYCLES cycles after the triggering strobe.
//   - Toward RX: rx_enable rises in cycle t+IFS_CYCLES, where t is the cycle tx_end was high.
//   - Toward TX: tx_start pulses in cycle t+IFS_CYCLES, where t is the cycle rx_decode_end was high.
//  RX_LISTEN:
//   - Counter decrements while nonzero.
//   - rx_hit_flag: go to RX_DECODE; counter = MAX_DECODE_CYCLES.
//   - Counter reaches 0 with a nonzero window: go to DONE, status RX_TIMEOUT.
//   - Hit and expiry in the same cycle: the hit wins.
//  RX_DECODE: rx_enable stays high.
//   - rx_decode_end with crc_ok in mode 3: go to IFS_WAIT toward TX; rx_enable drops next cycle.
//   - rx_decode_end with crc_ok in mode 1/2: go to DONE, status OK.
//   - rx_decode_end with !crc_ok: go to DONE, status CRC_ERR; no TX is issued.
//   - Watchdog expiry: go to DONE, status DECODE_TIMEOUT.
//  DONE: lasts 1 cycle; done = 1, rx_enable = 0, then IDLE.
//  abort in any state other than IDLE/DONE:
//   - Next state is DONE with status ABORT; rx_enable drops next cycle.
//   - Abort has priority over every simultaneous completion, hit or timer event.
//   - A pending tx_start for that cycle is suppressed.
//  start while busy: ignored, no side effects.
//  start with abort in IDLE: ignored.
//  Spurious tx_end/rx_* strobes outside their states: ignored.
//  Counter: one TIMER_BIT_WIDTH down-counter shared across states; it saturates at 0 (no wrap).
// STRUCTURE
//  Constants go in btle_config.v: mode codes, status codes and state encodings, as `defines guarded by ifndef.
//  No sub-module; one registered FSM, one counter and output registers.
//  btle_phy_trx (new top) instantiates btle_tx, btle_rx and this block.
//  rx_iq_valid to btle_rx = rx_iq_valid & rx_enable.
// TESTING
//  Use CLK_FREQ_MHZ=1, IFS_US=10 (IFS_CYCLES=10) for all scenarios.
//  1 TX_ONLY: start@0, tx_end@50 -> tx_start@1; done@51 with status 1; busy low @52.
//  2 TX_THEN_RX: tx_end@50, hit@80, decode_end+crc_ok@200 -> rx_enable 1 from @60 through @200; done@201, status 1.
//  3 RX_THEN_TX: decode_end+crc_ok@100 -> tx_start@110; tx_end@300 -> done@301, status 1.
//     Repeat with crc_ok=0 -> done@101, status 3, no tx_start.
//  4 RX_ONLY, timeout=20, start@0 -> status 2 and done@~21.
//     Repeat with hit and expiry in the same cycle -> stays in RX_DECODE.
//     Repeat with timeout=0 -> never times out.
//  5 Abort in each state, and abort coincident with tx_end or decode_end -> status 5 next cycle, rx_enable 0, no tx_start.
//  6 rst asserted mid-IFS_WAIT -> IDLE and all outputs 0 next cycle; start while busy -> no effect.

Source files
------------

// File: rtl/btle_phy_trx_seq_pkg.sv
// btle_phy_trx_seq_pkg: mode, status and FSM state encodings for the PHY TX/RX sequencer
package btle_phy_trx_seq_pkg;

   typedef enum logic [1:0] {
      MODE_TX_ONLY    = 2'd0,
      MODE_RX_ONLY    = 2'd1,
      MODE_TX_THEN_RX = 2'd2,
      MODE_RX_THEN_TX = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      ST_NONE           = 3'd0,
      ST_OK             = 3'd1,
      ST_RX_TIMEOUT     = 3'd2,
      ST_CRC_ERR        = 3'd3,
      ST_DECODE_TIMEOUT = 3'd4,
      ST_ABORT          = 3'd5
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TX_RUN    = 3'd1,
      S_IFS_WAIT  = 3'd2,
      S_RX_LISTEN = 3'd3,
      S_RX_DECODE = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   function automatic logic tx_first(input logic [1:0] m);
      return m == MODE_TX_ONLY || m == MODE_TX_THEN_RX;
   endfunction

endpackage

// File: rtl/btle_phy_trx_seq_if.sv
// btle_phy_trx_seq_if: control/strobe bundle between the PHY top and the TX/RX sequencer
//   master: drives start/abort/mode/rx_timeout_cycles and the btle_tx/btle_rx strobes
//   slave : the sequencer; drives tx_start, rx_enable, busy, done, status, state_dbg
interface btle_phy_trx_seq_if
   import btle_phy_trx_seq_pkg::*;
#(
   parameter int TIMER_BIT_WIDTH = 24
);
   logic                       start;
   logic                       abort;
   logic [1:0]                 mode;
   logic [TIMER_BIT_WIDTH-1:0] rx_timeout_cycles;
   logic                       tx_end;
   logic                       rx_hit_flag;
   logic                       rx_decode_end;
   logic                       rx_crc_ok;
   logic                       tx_start;
   logic                       rx_enable;
   logic                       busy;
   logic                       done;
   status_t                    status;
   state_t                     state_dbg;

   modport master (
      output start, abort, mode, rx_timeout_cycles, tx_end, rx_hit_flag, rx_decode_end, rx_crc_ok,
      input  tx_start, rx_enable, busy, done, status, state_dbg
   );

   modport slave (
      input  start, abort, mode, rx_timeout_cycles, tx_end, rx_hit_flag, rx_decode_end, rx_crc_ok,
      output tx_start, rx_enable, busy, done, status, state_dbg
   );
endinterface

// File: rtl/btle_phy_trx_seq.sv
// btle_phy_trx_seq: half-duplex TX/RX exchange sequencer with T_IFS turnaround, listen timeout and decode watchdog
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of btle_phy_trx_seq_if (requests and strobes in; tx_start, rx_enable,
//              busy, done, status, state_dbg out, all registered)
module btle_phy_trx_seq
   import btle_phy_trx_seq_pkg::*;
#(
   parameter int CLK_FREQ_MHZ      = 16,
   parameter int IFS_US            = 150,
   parameter int TIMER_BIT_WIDTH   = 24,
   parameter int MAX_DECODE_CYCLES = 35200
) (
   input logic              clk,
   input logic              rst,
   btle_phy_trx_seq_if.slave bus
);

   localparam int IFS_CYCLES = CLK_FREQ_MHZ * IFS_US;
   // The strobe cycle and the state-entry cycle account for two of the IFS cycles.
   localparam logic [TIMER_BIT_WIDTH-1:0] IFS_LOAD = TIMER_BIT_WIDTH'(IFS_CYCLES - 2);
   localparam logic [TIMER_BIT_WIDTH-1:0] DEC_LOAD = TIMER_BIT_WIDTH'(MAX_DECODE_CYCLES);

   state_t                     state, nxt;
   status_t                    status_q, status_n;
   mode_t                      mode_q;
   logic [TIMER_BIT_WIDTH-1:0] rx_to_q, cnt, cnt_n;
   logic                       accept, expire, active, to_rx, rx_then_tx;

   assign accept     = state == S_IDLE && bus.start && !bus.abort;
   // A loaded count of N expires in the Nth cycle; a zero load never expires.
   assign expire     = cnt == TIMER_BIT_WIDTH'(1);
   assign active     = state inside {S_TX_RUN, S_IFS_WAIT, S_RX_LISTEN, S_RX_DECODE};
   assign to_rx      = mode_q == MODE_TX_THEN_RX;
   assign rx_then_tx = mode_q == MODE_RX_THEN_TX;

   always_comb begin
      nxt      = state;
      status_n = status_q;
      cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
      case (state)
         S_IDLE: if (accept) begin
            nxt      = tx_first(bus.mode) ? S_TX_RUN : S_RX_LISTEN;
            status_n = ST_NONE;
            cnt_n    = bus.rx_timeout_cycles;
         end
         S_TX_RUN: if (bus.tx_end) begin
            nxt      = to_rx ? S_IFS_WAIT : S_DONE;
            status_n = to_rx ? status_q : ST_OK;
            cnt_n    = IFS_LOAD;
         end
         S_IFS_WAIT: if (cnt == '0) begin
            nxt   = to_rx ? S_RX_LISTEN : S_TX_RUN;
            cnt_n = rx_to_q;
         end
         S_RX_LISTEN:
            if (bus.rx_hit_flag) begin
               nxt   = S_RX_DECODE;
               cnt_n = DEC_LOAD;
            end else if (expire) begin
               nxt      = S_DONE;
               status_n = ST_RX_TIMEOUT;
            end
         S_RX_DECODE:
            if (bus.rx_decode_end) begin
               nxt      = (bus.rx_crc_ok && rx_then_tx) ? S_IFS_WAIT : S_DONE;
               status_n = !bus.rx_crc_ok ? ST_CRC_ERR : (rx_then_tx ? status_q : ST_OK);
               cnt_n    = IFS_LOAD;
            end else if (expire) begin
               nxt      = S_DONE;
               status_n = ST_DECODE_TIMEOUT;
            end
         default: nxt = S_IDLE;
      endcase
      // Abort overrides every completion, hit and timer event of the same cycle.
      if (active && bus.abort) begin
         nxt      = S_DONE;
         status_n = ST_ABORT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         status_q      <= ST_NONE;
         mode_q        <= MODE_TX_ONLY;
         rx_to_q       <= '0;
         cnt           <= '0;
         bus.tx_start  <= 1'b0;
         bus.rx_enable <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         state         <= nxt;
         status_q      <= status_n;
         cnt           <= cnt_n;
         mode_q        <= accept ? mode_t'(bus.mode) : mode_q;
         rx_to_q       <= accept ? bus.rx_timeout_cycles : rx_to_q;
         bus.tx_start  <= nxt == S_TX_RUN && state != S_TX_RUN;
         bus.rx_enable <= nxt inside {S_RX_LISTEN, S_RX_DECODE};
         bus.busy      <= nxt != S_IDLE;
         bus.done      <= nxt == S_DONE;
      end
   end

   assign bus.status    = status_q;
   assign bus.state_dbg = state;

endmodule
